// File: rtl/grid_frame_loader.sv
// Copies the 28x28 drawing grid into the network input buffer as Q16.16 activations,
// counts set pixels, and optionally wipes the grid afterwards.
module grid_frame_loader #(
   parameter int unsigned GRID_SIZE    = 28,
   parameter int unsigned NUM_PIXELS   = GRID_SIZE * GRID_SIZE,
   parameter logic [31:0] ON_VALUE     = 32'h0001_0000,
   parameter logic [31:0] OFF_VALUE    = 32'h0000_0000,
   parameter logic [15:0] NN_BASE_ADDR = 16'd0
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        start,
   input  logic        clear_after,
   output logic [15:0] grid_read_addr,
   input  logic [31:0] grid_data_read,
   output logic [15:0] grid_write_addr,
   output logic [31:0] grid_data_write,
   output logic        grid_write_enable,
   output logic [15:0] nn_write_addr,
   output logic [31:0] nn_data_write,
   output logic        nn_write_enable,
   output logic        busy,
   output logic        done,
   output logic [9:0]  pixel_count
);

   localparam int unsigned IDX_W = 10;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_STREAM = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_CLEAR  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]       r_state, w_state;
   logic [IDX_W-1:0] r_index, w_index;
   logic             r_clear_flag, w_clear_flag;
   logic             r_rd_valid, w_rd_valid;
   logic [IDX_W-1:0] r_rd_addr, w_rd_addr;
   logic [15:0]      r_grid_read_addr, w_grid_read_addr;
   logic [15:0]      r_grid_write_addr, w_grid_write_addr;
   logic             r_grid_we, w_grid_we;
   logic [15:0]      r_nn_addr, w_nn_addr;
   logic [31:0]      r_nn_data, w_nn_data;
   logic             r_nn_we, w_nn_we;
   logic             r_busy, w_busy;
   logic             r_done, w_done;
   logic [IDX_W-1:0] r_pixel_count, w_pixel_count;

   // Next-state and next-output logic; the read pipeline runs alongside the FSM.
   always_comb begin
      w_state           = r_state;
      w_index           = r_index;
      w_clear_flag      = r_clear_flag;
      w_pixel_count     = r_pixel_count;
      w_grid_we         = 1'b0;
      w_grid_write_addr = r_grid_write_addr;
      w_rd_valid        = (r_state == S_STREAM);
      w_rd_addr         = r_index;
      w_nn_we           = r_rd_valid;
      w_nn_addr         = r_nn_addr;
      w_nn_data         = r_nn_data;

      if (r_rd_valid) begin
         w_nn_addr = NN_BASE_ADDR + 16'(r_rd_addr);
         if (grid_data_read != 32'd0) begin
            w_nn_data     = ON_VALUE;
            w_pixel_count = r_pixel_count + IDX_W'(1);
         end else begin
            w_nn_data = OFF_VALUE;
         end
      end

      case (r_state)
         S_IDLE: begin
            // r_busy is still high in the cycle right after FINISH, so a start there is ignored
            if (start && !r_busy) begin
               w_clear_flag  = clear_after;
               w_pixel_count = '0;
               w_index       = '0;
               w_state       = S_STREAM;
            end
         end
         S_STREAM: begin
            if (r_index == LAST_IDX) begin
               w_index = '0;
               w_state = S_DRAIN;
            end else begin
               w_index = r_index + IDX_W'(1);
            end
         end
         S_DRAIN: begin
            // Hold until the last grid word has been turned into an nn write
            if (!r_rd_valid) begin
               w_state = r_clear_flag ? S_CLEAR : S_FINISH;
            end
         end
         S_CLEAR: begin
            w_grid_we         = 1'b1;
            w_grid_write_addr = 16'(r_index);
            if (r_index == LAST_IDX) begin
               w_index = '0;
               w_state = S_FINISH;
            end else begin
               w_index = r_index + IDX_W'(1);
            end
         end
         S_FINISH: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      w_busy           = (r_state != S_IDLE);
      w_done           = (r_state == S_FINISH);
      w_grid_read_addr = (w_state == S_STREAM) ? 16'(w_index) : 16'd0;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state           <= S_IDLE;
         r_index           <= '0;
         r_clear_flag      <= 1'b0;
         r_rd_valid        <= 1'b0;
         r_rd_addr         <= '0;
         r_grid_read_addr  <= '0;
         r_grid_write_addr <= '0;
         r_grid_we         <= 1'b0;
         r_nn_addr         <= '0;
         r_nn_data         <= '0;
         r_nn_we           <= 1'b0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_pixel_count     <= '0;
      end else begin
         r_state           <= w_state;
         r_index           <= w_index;
         r_clear_flag      <= w_clear_flag;
         r_rd_valid        <= w_rd_valid;
         r_rd_addr         <= w_rd_addr;
         r_grid_read_addr  <= w_grid_read_addr;
         r_grid_write_addr <= w_grid_write_addr;
         r_grid_we         <= w_grid_we;
         r_nn_addr         <= w_nn_addr;
         r_nn_data         <= w_nn_data;
         r_nn_we           <= w_nn_we;
         r_busy            <= w_busy;
         r_done            <= w_done;
         r_pixel_count     <= w_pixel_count;
      end
   end

   assign grid_read_addr    = r_grid_read_addr;
   assign grid_write_addr   = r_grid_write_addr;
   assign grid_data_write   = 32'd0;
   assign grid_write_enable = r_grid_we;
   assign nn_write_addr     = r_nn_addr;
   assign nn_data_write     = r_nn_data;
   assign nn_write_enable   = r_nn_we;
   assign busy              = r_busy;
   assign done              = r_done;
   assign pixel_count       = r_pixel_count;

endmodule

// File: tb/tb_grid_frame_loader.sv
// Scoreboard bench for grid_frame_loader: a synchronous grid memory model feeds the DUT,
// expected nn writes are queued per transfer and popped as the DUT writes them.
module tb_grid_frame_loader;

   localparam int unsigned NPIX = 784;
   localparam logic [31:0] ON   = 32'h0001_0000;

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } nn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        clear_after = 1'b0;
   logic [15:0] grid_read_addr, grid_write_addr, nn_write_addr;
   logic [31:0] grid_data_read, grid_data_write, nn_data_write;
   logic        grid_write_enable, nn_write_enable, busy, done;
   logic [9:0]  pixel_count;

   logic        tb_we = 1'b0;
   logic        tb_wipe = 1'b0;
   logic [9:0]  tb_addr = '0;
   logic [31:0] tb_data = '0;
   logic [31:0] grid_mem [0:1023];

   nn_t exp_q [$];
   int  tests = 0, fails = 0;
   int  cyc = 0;
   int  nn_cnt = 0, grid_cnt = 0, done_cnt = 0, done_cyc = 0, last_nn_cyc = 0;

   grid_frame_loader dut (
      .CLOCK_50          (clk),
      .resetn            (rst_n),
      .start             (start),
      .clear_after       (clear_after),
      .grid_read_addr    (grid_read_addr),
      .grid_data_read    (grid_data_read),
      .grid_write_addr   (grid_write_addr),
      .grid_data_write   (grid_data_write),
      .grid_write_enable (grid_write_enable),
      .nn_write_addr     (nn_write_addr),
      .nn_data_write     (nn_data_write),
      .nn_write_enable   (nn_write_enable),
      .busy              (busy),
      .done              (done),
      .pixel_count       (pixel_count)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Grid memory: registered read, bench preload port, DUT clear port
   always @(posedge clk) begin
      if (tb_wipe) begin
         for (int i = 0; i < 1024; i++) grid_mem[i] <= 32'd0;
      end else if (tb_we) begin
         grid_mem[tb_addr] <= tb_data;
      end else if (grid_write_enable && rst_n) begin
         grid_mem[grid_write_addr[9:0]] <= grid_data_write;
      end
      grid_data_read <= grid_mem[grid_read_addr[9:0]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (nn_write_enable) begin
            if (exp_q.size() == 0) begin
               check("nn_extra", 32'(1), 32'(0));
            end else begin
               nn_t e;
               e = exp_q.pop_front();
               check("nn_addr", 32'(nn_write_addr), 32'(e.a));
               check("nn_data", nn_data_write, e.d);
            end
            nn_cnt++;
            last_nn_cyc = cyc;
         end
         if (grid_write_enable) begin
            check("grid_wdata", grid_data_write, 32'd0);
            check("grid_waddr", 32'(grid_write_addr), 32'(grid_cnt % NPIX));
            check("grid_after_nn", 32'(cyc > last_nn_cyc), 32'(1));
            grid_cnt++;
         end
         if (done) begin
            check("busy_at_done", 32'(busy), 32'(1));
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic set_px(input int a, input logic [31:0] v);
      @(negedge clk);
      tb_we = 1'b1; tb_addr = 10'(a); tb_data = v;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic wipe();
      @(negedge clk);
      tb_wipe = 1'b1;
      @(negedge clk);
      tb_wipe = 1'b0;
   endtask

   task automatic push_exp();
      nn_t e;
      for (int i = 0; i < int'(NPIX); i++) begin
         e.a = 16'(i);
         e.d = (grid_mem[i] != 32'd0) ? ON : 32'd0;
         exp_q.push_back(e);
      end
   endtask

   task automatic run_xfer(input bit clr, input int hold, input bit repulse,
                           input int exp_pix, input int exp_lat);
      int nn0, g0, d0, t0, n, nz;
      nn0 = nn_cnt; g0 = grid_cnt; d0 = done_cnt;
      push_exp();
      @(negedge clk);
      start = 1'b1; clear_after = clr;
      @(posedge clk);
      #1 t0 = cyc;
      repeat (hold - 1) @(posedge clk);
      @(negedge clk);
      start = 1'b0; clear_after = ~clr;
      if (repulse) begin
         repeat (300) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      n = 0;
      while (done_cnt == d0 && n < 4000) begin
         @(negedge clk);
         #1 n++;
      end
      check("done_timeout", 32'(n < 4000), 32'(1));
      check("latency", 32'(done_cyc - t0), 32'(exp_lat));
      repeat (20) @(negedge clk);
      #1;
      check("done_pulses", 32'(done_cnt - d0), 32'(1));
      check("nn_writes", 32'(nn_cnt - nn0), 32'(NPIX));
      check("exp_q_empty", 32'(exp_q.size()), 32'(0));
      check("grid_writes", 32'(grid_cnt - g0), clr ? 32'(NPIX) : 32'(0));
      check("pixel_count", 32'(pixel_count), 32'(exp_pix));
      check("busy_idle", 32'(busy), 32'(0));
      if (clr) begin
         nz = 0;
         for (int i = 0; i < int'(NPIX); i++) if (grid_mem[i] != 32'd0) nz++;
         check("grid_blank", 32'(nz), 32'(0));
      end
      clear_after = 1'b0;
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_busy"}, 32'(busy), 32'(0));
      check({pfx, "_done"}, 32'(done), 32'(0));
      check({pfx, "_nn_we"}, 32'(nn_write_enable), 32'(0));
      check({pfx, "_nn_addr"}, 32'(nn_write_addr), 32'(0));
      check({pfx, "_nn_data"}, nn_data_write, 32'(0));
      check({pfx, "_grid_we"}, 32'(grid_write_enable), 32'(0));
      check({pfx, "_grid_raddr"}, 32'(grid_read_addr), 32'(0));
      check({pfx, "_pix"}, 32'(pixel_count), 32'(0));
   endtask

   initial begin
      int nn0, d0, n;
      #1 rst_n = 1'b0;
      #5 check_outputs_zero("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Empty grid
      wipe();
      run_xfer(1'b0, 1, 1'b0, 0, 787);

      // Corner and interior pixels
      set_px(0, 32'd1); set_px(29, 32'd1); set_px(783, 32'd1);
      run_xfer(1'b0, 1, 1'b0, 3, 787);

      // Any nonzero word counts as set
      wipe();
      set_px(100, 32'hFFFF_FFFF);
      run_xfer(1'b0, 1, 1'b0, 1, 787);

      // Clear pass, then a blank follow-up transfer
      wipe();
      for (int i = 0; i < 10; i++) set_px(i * 70 + 3, 32'd1);
      run_xfer(1'b1, 1, 1'b0, 10, 1571);
      run_xfer(1'b0, 1, 1'b0, 0, 787);

      // Held start plus a re-pulse while streaming
      wipe();
      set_px(5, 32'd1); set_px(6, 32'd7);
      run_xfer(1'b0, 5, 1'b1, 2, 787);

      // Reset in the middle of streaming
      wipe();
      set_px(5, 32'd1); set_px(450, 32'd1);
      push_exp();
      nn0 = nn_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (nn_cnt < nn0 + 400 && n < 2000) begin
         @(negedge clk);
         #1 n++;
      end
      check("abort_timeout", 32'(n < 2000), 32'(1));
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("abort");
      exp_q.delete();
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1 check("abort_no_done", 32'(done_cnt - d0), 32'(0));
      run_xfer(1'b0, 1, 1'b0, 2, 787);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
